// File: rtl/net_perf_monitor.sv
// Multi-channel throughput monitor: each channel arms on a trigger, counts beats over a
// programmable window and latches a snapshot. Define NET_PERF_SATURATE_EN for saturating counters.
module net_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 64,
    parameter int EVT_W  = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [31:0]             win_len,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       trig_valid,
    input  logic [NUM_CH-1:0]       trig_ready,
    input  logic [NUM_CH-1:0]       beat_valid,
    input  logic [NUM_CH-1:0]       beat_ready,
    input  logic [NUM_CH*LEN_W-1:0] beat_len,
    input  logic [NUM_CH-1:0]       beat_err,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH*CNT_W-1:0] snap_bytes,
    output logic [NUM_CH*EVT_W-1:0] snap_events,
    output logic [NUM_CH*EVT_W-1:0] snap_errors,
    output logic [NUM_CH-1:0]       snap_valid
);

    // One extra bit above the wider operand exposes the byte-sum carry-out.
    localparam int SUM_W = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t             state_q, state_d;
        logic [31:0]        len_q, len_d;
        logic [31:0]        cyc_q, cyc_d;
        logic [CNT_W-1:0]   bytes_q, bytes_d, sbytes_q, sbytes_d;
        logic [EVT_W-1:0]   events_q, events_d, sevents_q, sevents_d;
        logic [EVT_W-1:0]   errors_q, errors_d, serrors_q, serrors_d;
        logic               done_q, done_d;
        logic               sval_q, sval_d;
        logic               beat, trig, last;
        logic [SUM_W-1:0]   sum;
        logic [CNT_W-1:0]   bytes_inc;
        logic [EVT_W-1:0]   ev_inc, er_inc;

        always_comb begin
            beat = beat_valid[gi] & beat_ready[gi];
            trig = trig_valid[gi] & trig_ready[gi];
            last = (cyc_q == len_q - 32'd1);
            sum  = SUM_W'(bytes_q) + SUM_W'(beat_len[gi*LEN_W +: LEN_W]);
`ifdef NET_PERF_SATURATE_EN
            bytes_inc = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
            ev_inc    = (&events_q) ? events_q : events_q + EVT_W'(1);
            er_inc    = (&errors_q) ? errors_q : errors_q + EVT_W'(1);
`else
            bytes_inc = sum[CNT_W-1:0];
            ev_inc    = events_q + EVT_W'(1);
            er_inc    = errors_q + EVT_W'(1);
`endif
        end

        always_comb begin
            state_d   = state_q;
            len_d     = len_q;
            cyc_d     = cyc_q;
            bytes_d   = bytes_q;
            events_d  = events_q;
            errors_d  = errors_q;
            sbytes_d  = sbytes_q;
            sevents_d = sevents_q;
            serrors_d = serrors_q;
            sval_d    = sval_q;
            done_d    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        len_d    = (win_len == 32'd0) ? 32'd1 : win_len;
                        cyc_d    = '0;
                        bytes_d  = '0;
                        events_d = '0;
                        errors_d = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (beat_err[gi]) begin
                            errors_d = er_inc;
                        end else begin
                            bytes_d  = bytes_inc;
                            events_d = ev_inc;
                        end
                    end
                    cyc_d = cyc_q + 32'd1;
                    // The final cycle's beat is folded into the snapshot directly.
                    if (last) begin
                        state_d   = IDLE;
                        sbytes_d  = bytes_d;
                        sevents_d = events_d;
                        serrors_d = errors_d;
                        sval_d    = 1'b1;
                        done_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge aclk) begin
            if (areset || clear) begin
                state_q   <= IDLE;
                len_q     <= '0;
                cyc_q     <= '0;
                bytes_q   <= '0;
                events_q  <= '0;
                errors_q  <= '0;
                sbytes_q  <= '0;
                sevents_q <= '0;
                serrors_q <= '0;
                sval_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                len_q     <= len_d;
                cyc_q     <= cyc_d;
                bytes_q   <= bytes_d;
                events_q  <= events_d;
                errors_q  <= errors_d;
                sbytes_q  <= sbytes_d;
                sevents_q <= sevents_d;
                serrors_q <= serrors_d;
                sval_q    <= sval_d;
                done_q    <= done_d;
            end
        end

        assign busy[gi]                        = (state_q == RUN);
        assign done[gi]                        = done_q;
        assign snap_valid[gi]                  = sval_q;
        assign snap_bytes[gi*CNT_W +: CNT_W]   = sbytes_q;
        assign snap_events[gi*EVT_W +: EVT_W]  = sevents_q;
        assign snap_errors[gi*EVT_W +: EVT_W]  = serrors_q;
    end

endmodule

// File: tb/tb_net_perf_monitor.sv
// Scoreboard bench for net_perf_monitor: stimulus queues expected snapshots per channel,
// a negedge monitor pops and checks them whenever done pulses.
module tb_net_perf_monitor;

    localparam int NUM_CH = 4;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = 64;
    localparam int EVT_W  = 32;

    logic                    aclk = 1'b0;
    logic                    areset = 1'b1;
    logic [31:0]             win_len = '0;
    logic                    clear = 1'b0;
    logic [NUM_CH-1:0]       trig_valid = '0;
    logic [NUM_CH-1:0]       trig_ready = '0;
    logic [NUM_CH-1:0]       beat_valid = '0;
    logic [NUM_CH-1:0]       beat_ready = '0;
    logic [NUM_CH*LEN_W-1:0] beat_len = '0;
    logic [NUM_CH-1:0]       beat_err = '0;
    logic [NUM_CH-1:0]       busy, done, snap_valid;
    logic [NUM_CH*CNT_W-1:0] snap_bytes;
    logic [NUM_CH*EVT_W-1:0] snap_events, snap_errors;

    // Narrow-counter instance for the wrap/saturate check.
    logic       s_trig = 1'b0;
    logic       s_bvalid = 1'b0;
    logic [15:0] s_blen = '0;
    logic [0:0] s_busy, s_done, s_snap_valid;
    logic [7:0] s_snap_bytes;
    logic [31:0] s_snap_events, s_snap_errors;

    net_perf_monitor #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
        .aclk(aclk), .areset(areset), .win_len(win_len), .clear(clear),
        .trig_valid(trig_valid), .trig_ready(trig_ready),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_len(beat_len), .beat_err(beat_err),
        .busy(busy), .done(done), .snap_bytes(snap_bytes),
        .snap_events(snap_events), .snap_errors(snap_errors), .snap_valid(snap_valid)
    );

    net_perf_monitor #(.NUM_CH(1), .LEN_W(16), .CNT_W(8), .EVT_W(32)) dut_small (
        .aclk(aclk), .areset(areset), .win_len(win_len), .clear(clear),
        .trig_valid(s_trig), .trig_ready(s_trig),
        .beat_valid(s_bvalid), .beat_ready(s_bvalid),
        .beat_len(s_blen), .beat_err(1'b0),
        .busy(s_busy), .done(s_done), .snap_bytes(s_snap_bytes),
        .snap_events(s_snap_events), .snap_errors(s_snap_errors), .snap_valid(s_snap_valid)
    );

    always #5 aclk = ~aclk;

    int edge_cnt = 0;
    always @(posedge aclk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [63:0] bytes;
        logic [31:0] events;
        logic [31:0] errors;
        int          edge_no;
    } exp_t;

    exp_t exp_q[NUM_CH][$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input int c, input logic [63:0] b, input logic [31:0] ev,
                        input logic [31:0] er, input int e);
        exp_t x;
        x.bytes = b; x.events = ev; x.errors = er; x.edge_no = e;
        exp_q[c].push_back(x);
    endtask

    task automatic set_len(input int c, input logic [15:0] v);
        beat_len[c*LEN_W +: LEN_W] = v;
    endtask

    // Monitor: every done pulse must match the oldest expected snapshot of that channel.
    exp_t mon_e;
    always @(negedge aclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (done[c] === 1'b1) begin
                if (exp_q[c].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done ch%0d: got done=1 expected none (edge %0d)", c, edge_cnt);
                end else begin
                    mon_e = exp_q[c].pop_front();
                    $display("ch%0d window done edge=%0d bytes=%0d events=%0d errors=%0d", c, edge_cnt,
                             snap_bytes[c*CNT_W +: CNT_W], snap_events[c*EVT_W +: EVT_W],
                             snap_errors[c*EVT_W +: EVT_W]);
                    cmp($sformatf("done_edge_ch%0d", c), 64'(edge_cnt), 64'(mon_e.edge_no));
                    cmp($sformatf("snap_bytes_ch%0d", c), snap_bytes[c*CNT_W +: CNT_W], mon_e.bytes);
                    cmp($sformatf("snap_events_ch%0d", c), 64'(snap_events[c*EVT_W +: EVT_W]), 64'(mon_e.events));
                    cmp($sformatf("snap_errors_ch%0d", c), 64'(snap_errors[c*EVT_W +: EVT_W]), 64'(mon_e.errors));
                    cmp($sformatf("snap_valid_ch%0d", c), 64'(snap_valid[c]), 64'd1);
                end
            end
        end
    end

    int te, te2;
    int wins [NUM_CH];
    int lens [NUM_CH];
    logic [7:0] small_exp;

    initial begin
        // Reset
        repeat (3) tick();
        areset = 1'b0;
        cmp("reset_busy", 64'(busy), 64'd0);
        cmp("reset_done", 64'(done), 64'd0);
        cmp("reset_snap_valid", 64'(snap_valid), 64'd0);
        cmp("reset_snap_bytes0", snap_bytes[63:0], 64'd0);
        tick();

        // Window counting on ch0
        win_len = 10;
        trig_valid[0] = 1'b1; trig_ready[0] = 1'b1;
        tick();
        te = edge_cnt;
        trig_valid[0] = 1'b0; trig_ready[0] = 1'b0;
        push(0, 640, 10, 0, te + 10);
        cmp("t1_busy_rise", 64'(busy[0]), 64'd1);
        beat_valid[0] = 1'b1; beat_ready[0] = 1'b1; set_len(0, 64);
        repeat (9) tick();
        cmp("t1_busy_last", 64'(busy[0]), 64'd1);
        tick();
        cmp("t1_busy_fall", 64'(busy[0]), 64'd0);
        beat_valid[0] = 1'b0; beat_ready[0] = 1'b0;
        repeat (3) tick();

        // Errors, idle beats, ignored trigger during RUN on ch1
        win_len = 4;
        beat_valid[1] = 1'b1; beat_ready[1] = 1'b1; set_len(1, 999);
        repeat (2) tick();
        trig_valid[1] = 1'b1; trig_ready[1] = 1'b1;
        tick();
        te = edge_cnt;
        trig_valid[1] = 1'b0; trig_ready[1] = 1'b0;
        push(1, 200, 2, 2, te + 4);
        cmp("t2_busy_rise", 64'(busy[1]), 64'd1);
        set_len(1, 100);
        for (int i = 0; i < 4; i++) begin
            beat_err[1] = (i % 2 == 0);
            trig_valid[1] = (i == 1); trig_ready[1] = (i == 1);
            tick();
        end
        beat_valid[1] = 1'b0; beat_ready[1] = 1'b0; beat_err[1] = 1'b0;
        trig_valid[1] = 1'b0; trig_ready[1] = 1'b0;
        cmp("t2_busy_fall", 64'(busy[1]), 64'd0);
        repeat (3) tick();
        cmp("t2_no_restart", 64'(busy[1]), 64'd0);

        // Zero length window and boundary trigger on ch2
        win_len = 0;
        beat_valid[2] = 1'b1; beat_ready[2] = 1'b1; set_len(2, 5);
        trig_valid[2] = 1'b1; trig_ready[2] = 1'b1;
        tick();
        te = edge_cnt;
        push(2, 5, 1, 0, te + 1);
        cmp("t3_busy_rise", 64'(busy[2]), 64'd1);
        tick();
        cmp("t3_final_trig_ignored", 64'(busy[2]), 64'd0);
        tick();
        te2 = edge_cnt;
        push(2, 5, 1, 0, te2 + 1);
        cmp("t3_rearm", 64'(busy[2]), 64'd1);
        trig_valid[2] = 1'b0; trig_ready[2] = 1'b0;
        tick();
        beat_valid[2] = 1'b0; beat_ready[2] = 1'b0;
        repeat (3) tick();

        // Clear mid-window on ch2 and ch3
        win_len = 8;
        trig_valid[3:2] = 2'b11; trig_ready[3:2] = 2'b11;
        tick();
        trig_valid[3:2] = 2'b00; trig_ready[3:2] = 2'b00;
        beat_valid[3:2] = 2'b11; beat_ready[3:2] = 2'b11; set_len(2, 7); set_len(3, 7);
        repeat (3) tick();
        cmp("t4_busy_before_clear", 64'(busy[3:2]), 64'd3);
        cmp("t4_snap_valid_before_clear", 64'(snap_valid[1:0]), 64'd3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        beat_valid = '0; beat_ready = '0;
        cmp("t4_busy_after_clear", 64'(busy), 64'd0);
        cmp("t4_snap_valid_after_clear", 64'(snap_valid), 64'd0);
        cmp("t4_snap_bytes0_after_clear", snap_bytes[0*CNT_W +: CNT_W], 64'd0);
        cmp("t4_snap_events1_after_clear", 64'(snap_events[1*EVT_W +: EVT_W]), 64'd0);
        cmp("t4_done_after_clear", 64'(done), 64'd0);
        repeat (12) tick();

        // Independent channels, staggered arming with different window lengths
        wins[0] = 3; wins[1] = 5; wins[2] = 2; wins[3] = 6;
        lens[0] = 10; lens[1] = 20; lens[2] = 30; lens[3] = 40;
        for (int c = 0; c < NUM_CH; c++) set_len(c, 16'(lens[c]));
        beat_valid = '1; beat_ready = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            win_len = 32'(wins[c]);
            trig_valid = '0; trig_ready = '0;
            trig_valid[c] = 1'b1; trig_ready[c] = 1'b1;
            tick();
            push(c, 64'(wins[c] * lens[c]), 32'(wins[c]), 0, edge_cnt + wins[c]);
        end
        trig_valid = '0; trig_ready = '0;
        win_len = 1;
        repeat (10) tick();
        beat_valid = '0; beat_ready = '0;
        repeat (3) tick();

        // Wrap versus saturate with an 8-bit byte counter
`ifdef NET_PERF_SATURATE_EN
        small_exp = 8'd255;
`else
        small_exp = 8'd144;
`endif
        win_len = 2;
        s_trig = 1'b1;
        tick();
        s_trig = 1'b0;
        s_bvalid = 1'b1; s_blen = 16'd200;
        repeat (2) tick();
        s_bvalid = 1'b0;
        $display("small window done=%0d bytes=%0d events=%0d", s_done, s_snap_bytes, s_snap_events);
        cmp("t5_small_done", 64'(s_done), 64'd1);
        cmp("t5_small_bytes", 64'(s_snap_bytes), 64'(small_exp));
        cmp("t5_small_events", 64'(s_snap_events), 64'd2);
        repeat (2) tick();

        for (int c = 0; c < NUM_CH; c++) begin
            while (exp_q[c].size() != 0) begin
                void'(exp_q[c].pop_front());
                vectors++;
                miscompares++;
                $display("FAIL missing_done ch%0d: got no done expected a snapshot", c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
